// File: rtl/boot_packet_loader.sv
// Boot-load receiver: turns a stream of 16-bit NoC packets into 64-bit instruction
// writes plus the latched epilogue, sleep and countdown values for the schedule logic.
module boot_packet_loader #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 11,
   parameter int IMEM_DEPTH = 4096,
   parameter int IMEM_AW    = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     io_packet_in_data,
   input  logic [ADDR_W-1:0]     io_packet_in_address,
   input  logic                  io_packet_in_valid,
   output logic                  io_imem_wen,
   output logic [IMEM_AW-1:0]    io_imem_waddr,
   output logic [4*DATA_W-1:0]   io_imem_wdata,
   output logic [DATA_W-1:0]     io_body_length,
   output logic [DATA_W-1:0]     io_epilogue_length,
   output logic [DATA_W-1:0]     io_sleep_length,
   output logic [DATA_W-1:0]     io_countdown,
   output logic                  io_boot_done,
   output logic                  io_boot_error
);

   typedef enum logic [2:0] {
      S_BODY_LEN,
      S_BODY,
      S_EPILOGUE,
      S_SLEEP,
      S_COUNTDOWN,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state;
   logic [1:0]            word_cnt;
   logic [IMEM_AW:0]      slot;
   logic [3*DATA_W-1:0]   held_words;

   logic addr_ctrl;
   logic addr_body;
   logic len_oversize;
   logic last_slot;

   assign addr_ctrl    = (io_packet_in_address == '0);
   assign addr_body    = (io_packet_in_address == ADDR_W'(1));
   assign len_oversize = ({1'b0, io_packet_in_data} > (DATA_W+1)'(IMEM_DEPTH));
   // Slot counter is one bit wider than the address so a full memory never wraps.
   assign last_slot    = ((DATA_W'(slot) + DATA_W'(1)) == io_body_length);

   // NOTE: all state here is sequential, so every assignment is non-blocking (<=);
   // blocking assignments would make the result depend on statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state              <= S_BODY_LEN;
         word_cnt           <= '0;
         slot               <= '0;
         held_words         <= '0;
         io_imem_wen        <= 1'b0;
         io_imem_waddr      <= '0;
         io_imem_wdata      <= '0;
         io_body_length     <= '0;
         io_epilogue_length <= '0;
         io_sleep_length    <= '0;
         io_countdown       <= '0;
         io_boot_done       <= 1'b0;
         io_boot_error      <= 1'b0;
      end else begin
         // NOTE: the strobe defaults low every cycle so a write lasts exactly one clock.
         io_imem_wen <= 1'b0;
         if (io_packet_in_valid) begin
            case (state)
               S_BODY_LEN: begin
                  if (addr_ctrl) begin
                     io_body_length <= io_packet_in_data;
                     word_cnt       <= '0;
                     slot           <= '0;
                     if (io_packet_in_data == '0) begin
                        state <= S_EPILOGUE;
                     end else if (len_oversize) begin
                        state         <= S_ERROR;
                        io_boot_error <= 1'b1;
                     end else begin
                        state <= S_BODY;
                     end
                  end else begin
                     state         <= S_ERROR;
                     io_boot_error <= 1'b1;
                  end
               end
               S_BODY: begin
                  if (addr_body) begin
                     if (word_cnt == 2'd3) begin
                        // Earlier words sit in the low lanes; the 4th lands in the top lane.
                        io_imem_wen   <= 1'b1;
                        io_imem_waddr <= slot[IMEM_AW-1:0];
                        io_imem_wdata <= {io_packet_in_data, held_words};
                        word_cnt      <= '0;
                        slot          <= slot + 1'b1;
                        if (last_slot) state <= S_EPILOGUE;
                     end else begin
                        held_words <= {io_packet_in_data, held_words[3*DATA_W-1:DATA_W]};
                        word_cnt   <= word_cnt + 1'b1;
                     end
                  end else begin
                     state         <= S_ERROR;
                     io_boot_error <= 1'b1;
                  end
               end
               S_EPILOGUE, S_SLEEP, S_COUNTDOWN: begin
                  if (addr_ctrl) begin
                     if (state == S_EPILOGUE) begin
                        io_epilogue_length <= io_packet_in_data;
                        state              <= S_SLEEP;
                     end else if (state == S_SLEEP) begin
                        io_sleep_length <= io_packet_in_data;
                        state           <= S_COUNTDOWN;
                     end else begin
                        io_countdown <= io_packet_in_data;
                        io_boot_done <= 1'b1;
                        state        <= S_DONE;
                     end
                  end else begin
                     state         <= S_ERROR;
                     io_boot_error <= 1'b1;
                  end
               end
               default: ; // S_DONE and S_ERROR ignore traffic until reset
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_packet_loader.sv
// Randomized scoreboard bench for boot_packet_loader: a stream-level reference model
// predicts the instruction writes and latched values; a monitor checks each write.
module tb_boot_packet_loader;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 11;
   localparam int IMEM_DEPTH = 4096;
   localparam int IMEM_AW    = 12;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } pkt_t;

   typedef struct {
      logic [IMEM_AW-1:0] addr;
      logic [63:0]        data;
   } wr_t;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic [DATA_W-1:0]    pkt_data = '0;
   logic [ADDR_W-1:0]    pkt_addr = '0;
   logic                 pkt_valid = 1'b0;
   logic                 imem_wen;
   logic [IMEM_AW-1:0]   imem_waddr;
   logic [63:0]          imem_wdata;
   logic [DATA_W-1:0]    body_length, epilogue_length, sleep_length, countdown;
   logic                 boot_done, boot_error;

   int checks = 0;
   int errors = 0;

   wr_t  exp_q[$];
   pkt_t stim[$];
   int   m_body, m_epi, m_sleep, m_cd;
   bit   m_done, m_err;

   boot_packet_loader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(IMEM_DEPTH), .IMEM_AW(IMEM_AW)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .io_packet_in_data    (pkt_data),
      .io_packet_in_address (pkt_addr),
      .io_packet_in_valid   (pkt_valid),
      .io_imem_wen          (imem_wen),
      .io_imem_waddr        (imem_waddr),
      .io_imem_wdata        (imem_wdata),
      .io_body_length       (body_length),
      .io_epilogue_length   (epilogue_length),
      .io_sleep_length      (sleep_length),
      .io_countdown         (countdown),
      .io_boot_done         (boot_done),
      .io_boot_error        (boot_error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest predicted write.
   always @(negedge clock) begin : monitor
      wr_t w;
      if (reset && imem_wen) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_waddr, imem_wdata);
         end else begin
            w = exp_q.pop_front();
            check("imem_waddr", 64'(imem_waddr), 64'(w.addr));
            check("imem_wdata", imem_wdata, w.data);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic int exp_addr(input int i, input int len);
      if (i == 0) return 0;
      if (i <= 4 * len) return 1;
      return 0;
   endfunction

   // Stream-level model: find the first packet whose address breaks the expected
   // layout, then everything consumed before it takes effect and the rest is ignored.
   task automatic run_model(input pkt_t pk[$]);
      int n, len, lim, cut;
      wr_t w;
      m_body = 0; m_epi = 0; m_sleep = 0; m_cd = 0; m_done = 0; m_err = 0;
      n = pk.size();
      if (n == 0) return;
      if (pk[0].addr != 0) begin
         m_err = 1;
         return;
      end
      len    = int'(pk[0].data);
      m_body = len;
      if (len > IMEM_DEPTH) begin
         m_err = 1;
         return;
      end
      lim = 4 * len + 4;
      cut = (n < lim) ? n : lim;
      for (int i = 1; i < cut; i++) begin
         if (int'(pk[i].addr) != exp_addr(i, len)) begin
            cut   = i;
            m_err = 1;
            break;
         end
      end
      for (int k = 0; k < len; k++) begin
         if (4 * k + 4 < cut) begin
            w.addr = IMEM_AW'(k);
            w.data = {pk[4*k+4].data, pk[4*k+3].data, pk[4*k+2].data, pk[4*k+1].data};
            exp_q.push_back(w);
         end
      end
      if (4 * len + 1 < cut) m_epi   = int'(pk[4*len+1].data);
      if (4 * len + 2 < cut) m_sleep = int'(pk[4*len+2].data);
      if (4 * len + 3 < cut) begin
         m_cd   = int'(pk[4*len+3].data);
         m_done = 1;
      end
   endtask

   task automatic add(input int a, input int d);
      pkt_t p;
      p.addr = ADDR_W'(a);
      p.data = DATA_W'(d);
      stim.push_back(p);
   endtask

   task automatic build_full(input int len);
      add(0, len);
      for (int k = 0; k < len; k++) begin
         add(1, k); add(1, 0); add(1, 0); add(1, 0);
      end
      add(0, 4); add(0, 4); add(0, 4);
   endtask

   // Drive one packet at a falling edge; idle cycles carry junk that must be ignored.
   task automatic send_pkt(input pkt_t p, input int gap);
      pkt_valid = 1'b1;
      pkt_addr  = p.addr;
      pkt_data  = p.data;
      @(negedge clock);
      pkt_valid = 1'b0;
      pkt_addr  = ADDR_W'($urandom);
      pkt_data  = DATA_W'($urandom);
      repeat (gap) @(negedge clock);
   endtask

   task automatic send_range(input int from, input int to, input int max_gap);
      for (int i = from; i < to; i++)
         send_pkt(stim[i], (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0);
   endtask

   task automatic check_final(input string tag);
      repeat (2) @(negedge clock);
      #1;
      check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_body_length"},    64'(body_length),     64'(m_body));
      check({tag, "_epilogue"},       64'(epilogue_length), 64'(m_epi));
      check({tag, "_sleep"},          64'(sleep_length),    64'(m_sleep));
      check({tag, "_countdown"},      64'(countdown),       64'(m_cd));
      check({tag, "_boot_done"},      64'(boot_done),       64'(m_done));
      check({tag, "_boot_error"},     64'(boot_error),      64'(m_err));
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_wen",      64'(imem_wen), 64'd0);
      check("rst_waddr",    64'(imem_waddr), 64'd0);
      check("rst_wdata",    imem_wdata, 64'd0);
      check("rst_outputs",  64'({body_length, epilogue_length, sleep_length, countdown}), 64'd0);
      check("rst_flags",    64'({boot_done, boot_error}), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      stim.delete();
   endtask

   initial begin
      int n;
      pkt_t p;
      apply_reset();

      // Full stream, back to back; boot_done must rise right after the last packet.
      build_full(7);
      run_model(stim);
      n = stim.size();
      send_range(0, n - 1, 0);
      check("full_done_early", 64'(boot_done), 64'd0);
      send_range(n - 1, n, 0);
      check("full_done_latency", 64'(boot_done), 64'd1);
      check_final("full");

      // Same stream with idle gaps, including inside instructions.
      apply_reset();
      build_full(7);
      run_model(stim);
      send_range(0, stim.size(), 3);
      check_final("gapped");

      // Empty body, then extra packets that sDone must ignore.
      apply_reset();
      add(0, 0); add(0, 2); add(0, 3); add(0, 5); add(0, 9); add(1, 7);
      run_model(stim);
      send_range(0, stim.size(), 0);
      check_final("empty");

      // Control word in the middle of the body, then a full stream that stays ignored.
      apply_reset();
      add(0, 2); add(1, 11); add(1, 12); add(0, 13);
      build_full(3);
      run_model(stim);
      send_range(0, stim.size(), 1);
      check_final("proto_err");

      // Oversize body length: error on the next cycle.
      apply_reset();
      add(0, IMEM_DEPTH + 1);
      build_full(1);
      run_model(stim);
      send_range(0, 1, 0);
      check("oversize_err_latency", 64'(boot_error), 64'd1);
      send_range(1, stim.size(), 0);
      check_final("oversize");

      // Largest legal length must not be rejected (only the header is sent).
      apply_reset();
      add(0, IMEM_DEPTH);
      run_model(stim);
      send_range(0, 1, 0);
      check("maxlen_no_err", 64'(boot_error), 64'd0);
      check_final("maxlen");

      // Random streams with occasional corrupted addresses and random gaps.
      for (int it = 0; it < 8; it++) begin
         int len;
         apply_reset();
         len = int'($urandom_range(0, 5));
         for (int i = 0; i < 4 * len + 6; i++) begin
            p.addr = ADDR_W'(exp_addr(i, len));
            if ($urandom_range(0, 29) == 0) p.addr = ADDR_W'($urandom_range(0, 2047));
            p.data = DATA_W'($urandom);
            if (i == 0 && p.addr == 0) p.data = DATA_W'(len);
            stim.push_back(p);
         end
         run_model(stim);
         send_range(0, stim.size(), int'($urandom_range(0, 2)));
         check_final("random");
      end

      // Reset in the middle of the body, then a fresh one-instruction stream.
      apply_reset();
      build_full(7);
      while (stim.size() > 6) void'(stim.pop_back());
      run_model(stim);
      send_range(0, stim.size(), 0);
      #1;
      check("midbody_pending", 64'(exp_q.size()), 64'd0);
      apply_reset();
      add(0, 1);
      for (int i = 0; i < 4; i++) add(1, int'($urandom_range(0, 65535)));
      add(0, 6); add(0, 7); add(0, 8);
      run_model(stim);
      send_range(0, stim.size(), 1);
      check_final("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
